// File: rtl/ir_blob_decoder.sv
// ir_blob_decoder
//   Parses the extended-mode report byte stream from the IR camera into a
//   10-bit x/y blob position plus size nibble and present-blob count.
//   A frame is HEADER_BYTES header bytes followed by NUM_BLOBS 3-byte records
//   {xl, yl, hi}. Outputs change only on a complete frame (commit) or on the
//   no-frame timeout; y==1023 means "no data".
//
//   Optional feature macro: BLOB_SELECT_LARGEST_EN
//     defined   : report the present blob with the largest size nibble
//                 (ties -> lowest index)
//     undefined : report blob 0 only (1023/1023/0xF if blob 0 absent)
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   data_in[7:0]  camera report byte
//   data_valid    single-cycle strobe per byte
//   frame_start   marks data_in as byte 0 of a new report (with data_valid)
//   x[9:0], y[9:0], blob_size[3:0], blob_count[2:0]  last committed result
//   frame_valid   1-cycle pulse on commit
//   stale         no frame committed within TIMEOUT_CYCLES (or since reset)
module ir_blob_decoder #(
  parameter int HEADER_BYTES   = 1,
  parameter int NUM_BLOBS      = 4,
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       frame_start,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [3:0] blob_size,
  output logic [2:0] blob_count,
  output logic       frame_valid,
  output logic       stale
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HEADER_BYTES + 2);
  localparam logic [9:0] NONE = 10'h3FF;

  typedef enum logic [2:0] {IDLE, HDR, XL, YL, HI, COMMIT, SKIP} state_e;

  state_e         state_q, state_d;
  logic [HW-1:0]  hdr_q, hdr_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     xl_q, yl_q;
  // per-frame shadow: running selection and count
  logic           acc_vld_q;
  logic [9:0]     acc_x_q, acc_y_q;
  logic [3:0]     acc_sz_q;
  logic [2:0]     acc_cnt_q;
  logic [9:0]     x_q, y_q;
  logic [3:0]     sz_q;
  logic [2:0]     cnt_q;
  logic           stale_q;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic           start, hi_fire, last;
  logic [9:0]     rec_x, rec_y;
  logic [3:0]     rec_sz;
  logic           present, take;
  logic           m_vld;
  logic [9:0]     m_x, m_y;
  logic [3:0]     m_sz;
  logic [2:0]     m_cnt;

  // FSM next state
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    idx_d   = idx_q;
    start   = 1'b0;
    hi_fire = 1'b0;
    last    = 1'b0;
    if (data_valid && frame_start) begin
      // restart from any state; this byte is header byte 0 (or blob 0 xl)
      start = 1'b1;
      idx_d = '0;
      hdr_d = HW'(1);
      if (HEADER_BYTES == 0)      state_d = YL;
      else if (HEADER_BYTES == 1) state_d = XL;
      else                        state_d = HDR;
    end else begin
      unique case (state_q)
        HDR: if (data_valid) begin
          hdr_d = hdr_q + HW'(1);
          if (hdr_q == HW'(HEADER_BYTES - 1)) state_d = XL;
        end
        XL: if (data_valid) state_d = YL;
        YL: if (data_valid) state_d = HI;
        HI: if (data_valid) begin
          hi_fire = 1'b1;
          if (idx_q == 2'(NUM_BLOBS - 1)) begin
            last    = 1'b1;
            state_d = COMMIT;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = XL;
          end
        end
        COMMIT:  state_d = SKIP;
        default: state_d = state_q;  // IDLE/SKIP wait for frame_start
      endcase
    end
  end

  // Record decode and merge of the current record into the shadow. The
  // merged view feeds the outputs directly so commit costs only one clock.
  always_comb begin
    rec_x   = {data_in[5:4], xl_q};
    rec_y   = {data_in[7:6], yl_q};
    rec_sz  = data_in[3:0];
    present = (rec_y != NONE);
`ifdef BLOB_SELECT_LARGEST_EN
    // strict compare keeps the lowest index on ties
    take = present && (!acc_vld_q || (rec_sz > acc_sz_q));
`else
    take = present && (idx_q == 2'd0);
`endif
    m_vld = acc_vld_q | take;
    m_x   = take ? rec_x  : acc_x_q;
    m_y   = take ? rec_y  : acc_y_q;
    m_sz  = take ? rec_sz : acc_sz_q;
    m_cnt = acc_cnt_q + {2'b00, present};
    tmo_d = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      idx_q     <= '0;
      xl_q      <= '0;
      yl_q      <= '0;
      acc_vld_q <= 1'b0;
      acc_x_q   <= NONE;
      acc_y_q   <= NONE;
      acc_sz_q  <= 4'hF;
      acc_cnt_q <= '0;
      x_q       <= NONE;
      y_q       <= NONE;
      sz_q      <= 4'hF;
      cnt_q     <= '0;
      stale_q   <= 1'b1;
      tmo_q     <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      idx_q   <= idx_d;

      if (start) begin
        acc_vld_q <= 1'b0;
        acc_sz_q  <= 4'hF;
        acc_cnt_q <= '0;
        if (HEADER_BYTES == 0) xl_q <= data_in;
      end else if (data_valid && state_q == XL) begin
        xl_q <= data_in;
      end else if (data_valid && state_q == YL) begin
        yl_q <= data_in;
      end else if (hi_fire) begin
        acc_vld_q <= m_vld;
        acc_x_q   <= m_x;
        acc_y_q   <= m_y;
        acc_sz_q  <= m_sz;
        acc_cnt_q <= m_cnt;
      end

      if (last) begin
        x_q     <= m_vld ? m_x  : NONE;
        y_q     <= m_vld ? m_y  : NONE;
        sz_q    <= m_vld ? m_sz : 4'hF;
        cnt_q   <= m_cnt;
        stale_q <= 1'b0;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_d;
        if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
          x_q     <= NONE;
          y_q     <= NONE;
          sz_q    <= 4'hF;
          cnt_q   <= '0;
          stale_q <= 1'b1;
        end
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign blob_size   = sz_q;
  assign blob_count  = cnt_q;
  assign frame_valid = (state_q == COMMIT);
  assign stale       = stale_q;
endmodule

// File: tb/tb_ir_blob_decoder.sv
module tb_ir_blob_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       frame_start;
  logic [9:0] x, y;
  logic [3:0] blob_size;
  logic [2:0] blob_count;
  logic       frame_valid, stale;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  logic [7:0] frm [13];

  ir_blob_decoder #(.HEADER_BYTES(1), .NUM_BLOBS(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .frame_start(frame_start), .x(x), .y(y), .blob_size(blob_size),
    .blob_count(blob_count), .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fs);
    data_in = b; frame_start = fs; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0; frame_start = 1'b0;
  endtask

  // send the first n bytes of frm, frame_start on byte 0, random gaps
  task automatic send_frame(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      if (i != 0 && maxgap > 0) step($urandom_range(0, maxgap));
      send(frm[i], i == 0);
    end
  endtask

  task automatic chk_out(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                         input logic [3:0] es, input logic [2:0] ec);
    chk({tag, "_x"}, 32'(x), 32'(ex));
    chk({tag, "_y"}, 32'(y), 32'(ey));
    chk({tag, "_sz"}, 32'(blob_size), 32'(es));
    chk({tag, "_cnt"}, 32'(blob_count), 32'(ec));
  endtask

  initial begin
    reset = 1'b1; data_in = '0; data_valid = 1'b0; frame_start = 1'b0;
    step(3);
    reset = 1'b0;
    step(10);
    chk_out("rst", 10'h3FF, 10'h3FF, 4'hF, 3'd0);
    chk("rst_stale", 32'(stale), 1);
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_pulses", pulses, 0);

    // single blob frame, back to back bytes
    frm = '{8'h00, 8'h34, 8'h12, 8'h9A, 8'hFF, 8'hFF, 8'hFF,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(12, 0);
    chk("a_nopulse_early", pulses, 0);
    send(frm[12], 1'b0);
    chk("a_fv", 32'(frame_valid), 1);
    chk_out("a", 10'h134, 10'h212, 4'hA, 3'd1);
    chk("a_stale", 32'(stale), 0);
    step(1);
    chk("a_fv_drop", 32'(frame_valid), 0);
    chk("a_pulses", pulses, 1);

    // same frame with random gaps
    step(3);
    send_frame(13, 5);
    chk("b_fv", 32'(frame_valid), 1);
    chk_out("b", 10'h134, 10'h212, 4'hA, 3'd1);
    step(2);
    chk("b_pulses", pulses, 2);

    // partial frame aborted by frame_start, then an empty frame
    frm = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 8'hFF,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(5, 2);
    step(2);
    chk("abort_pulses", pulses, 2);
    chk_out("abort_hold", 10'h134, 10'h212, 4'hA, 3'd1);
    frm = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(13, 0);
    chk("empty_fv", 32'(frame_valid), 1);
    chk_out("empty", 10'h3FF, 10'h3FF, 4'hF, 3'd0);
    chk("empty_stale", 32'(stale), 0);
    step(1);
    chk("empty_pulses", pulses, 3);

    // blob0 size 2, blob2 size 7
    frm = '{8'h00, 8'h11, 8'h22, 8'h02, 8'hFF, 8'hFF, 8'hFF,
            8'h55, 8'h66, 8'h07, 8'hFF, 8'hFF, 8'hFF};
    send_frame(13, 1);
    chk("sel_fv", 32'(frame_valid), 1);
`ifdef BLOB_SELECT_LARGEST_EN
    chk_out("sel", 10'h055, 10'h066, 4'h7, 3'd2);
`else
    chk_out("sel", 10'h011, 10'h022, 4'h2, 3'd2);
`endif

    // blob0 absent, blob1 present size 3
    step(2);
    frm = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h53,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(13, 0);
`ifdef BLOB_SELECT_LARGEST_EN
    chk_out("b0abs", 10'h101, 10'h102, 4'h3, 3'd1);
`else
    chk_out("b0abs", 10'h3FF, 10'h3FF, 4'hF, 3'd1);
`endif

    // timeout: exactly 100 clocks after the commit
    p0 = pulses;
    step(99);
    chk("tmo99_stale", 32'(stale), 0);
    chk("tmo99_cnt", 32'(blob_count), 1);
    step(1);
    chk("tmo100_stale", 32'(stale), 1);
    chk_out("tmo100", 10'h3FF, 10'h3FF, 4'hF, 3'd0);
    // stray bytes without frame_start are ignored while idle
    send(8'h00, 1'b0);
    send(8'h34, 1'b0);
    send(8'h12, 1'b0);
    send(8'h9A, 1'b0);
    step(5);
    chk("tmo_pulses", pulses, p0 + 1);
    chk("stray_stale", 32'(stale), 1);

    // recovery after stale
    frm = '{8'h00, 8'h34, 8'h12, 8'h9A, 8'hFF, 8'hFF, 8'hFF,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(13, 0);
    chk("rec_fv", 32'(frame_valid), 1);
    chk("rec_stale", 32'(stale), 0);
    chk_out("rec", 10'h134, 10'h212, 4'hA, 3'd1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
